nibble_select_tree: RTL and testbench
=====================================

// Module: nibble_select_tree
// PURPOSE
//  Parametrised, pipelined min/max selector over N_IN lanes of WIDTH bits, packed in one bus.
//  Outputs the winning value and its lane index, with valid/ready flow control.
//  Optional peak-hold accumulates the extreme value across successive samples.
//  Generalises the 4-nibble max selector; sits between the nibble datapath and the stats/report logic.
// PARAMETERS
//  WIDTH   4  bits per lane
//  N_IN    8  lane count; power of two, 2..64
//  LEVELS  $clog2(N_IN)  tree depth (derived, not overridden)
// PORTS
//  CLK        in   1              clock, rising edge
//  RESET_L    in   1              reset, asynchronous assert, active low
//  IN_VALID   in   1              IN_DATA/MODE valid this cycle
//  IN_READY   out  1              block accepts the sample this cycle
//  IN_DATA    in   N_IN*WIDTH     lane i = IN_DATA[i*WIDTH +: WIDTH]
//  MODE       in   1              0 = select max, 1 = select min; sampled with IN_DATA
//  PEAK_EN    in   1              1 = accumulate the extreme value across samples
//  PEAK_CLR   in   1              synchronous clear of the held peak
//  OUT_VALID  out  1              OUT_DATA/OUT_IDX valid
//  OUT_READY  in   1              downstream accepts the output
//  OUT_DATA   out  WIDTH          winning value
//  OUT_IDX    out  LEVELS         winning lane index
// BEHAVIOUR
//  - Reset (RESET_L=0, async): all stage valids 0, OUT_VALID=0, OUT_DATA=0, OUT_IDX=0.
//    Held peak is invalid. IN_READY=1 once reset is released.
//  - Transfer in = IN_VALID&IN_READY. Transfer out = OUT_VALID&OUT_READY.
//  - Pipeline: one register per tree level, plus the output register.
//    Latency = LEVELS+1 cycles from transfer in to OUT_VALID (N_IN=8 -> 4). Throughput is 1 per cycle.
//  - Stall: stall = OUT_VALID & ~OUT_READY. While stalled, every stage holds its value and IN_READY=0.
//    IN_READY = ~stall (combinational). Bubbles do not collapse; the whole pipe freezes.
//  - Node compare (unsigned): max mode picks a>b ? a : b; min mode picks a<b ? a : b.
//    Ties go to the lower lane index. So for equal lanes, OUT_IDX is the smallest index.
//  - MODE travels down the pipe with its sample; mixed modes in flight are legal.
//  - Peak hold, evaluated at the output-register load (stage LEVELS -> output):
//    - PEAK_EN=0: output = tree result. The held peak is not updated.
//    - PEAK_EN=1, held invalid: output = tree result, and the result is stored as the held peak.
//    - PEAK_EN=1, held valid: output = better of (held, new) under this sample's MODE.
//      A tie keeps the held value and its index. The output is written back as the held peak.
//    - The held peak updates only on cycles where the output register loads (not stalled, stage valid).
//  - PEAK_CLR=1 invalidates the held peak. If a load happens in the same cycle, the clear applies first:
//    the new sample becomes the held peak and the output. PEAK_CLR does not touch pipeline data.
//  - OUT_DATA/OUT_IDX hold their value while OUT_VALID=0 or while stalled.
//  - Reset mid-operation flushes all in-flight samples; nothing in flight is output afterwards.
// STRUCTURE
//  - Package nibble_sel_pkg: MODE_MAX/MODE_MIN encodings; function sel_better(a,b,mode) -> 1 if b beats a.
//  - Sub-module nibble_select_node: registered 2:1 compare carrying {valid,mode,data,idx}.
//    It has a stall enable and an async reset. The tree is built with generate: N_IN/2^(l+1) nodes at level l.
//  - Top level holds the output register, the peak register (data, idx, valid) and the IN_READY logic.
// TESTING
//  1 Reset: assert RESET_L=0 mid-stream with 3 samples in flight.
//    -> OUT_VALID=0 at once, OUT_DATA=0, OUT_IDX=0; no stale output after release.
//  2 Max, N_IN=8, lanes {0:3,1:9,2:F,3:1,4:F,5:0,6:2,7:8}, MODE=0, OUT_READY=1.
//    -> OUT_DATA=F, OUT_IDX=2, exactly 4 cycles after accept.
//  3 Min, lanes all 7 except lane5=2 and lane6=2, MODE=1 -> OUT_DATA=2, OUT_IDX=5.
//    Then back-to-back max/min/max samples -> results in order, one per cycle.
//  4 Stall: hold OUT_READY=0 for 5 cycles with 6 samples streamed.
//    -> IN_READY=0 while stalled, OUT_DATA stable; after release all 6 come out in order, none lost or duplicated.
//  5 Peak: PEAK_EN=1 max, sample maxima 5 (lane3), 9 (lane0), 4 (lane7), 9 (lane6).
//    -> outputs 5/3, 9/0, 9/0, 9/0 (tie keeps held).
//  6 PEAK_CLR in the same cycle as the 4th load above -> output 9/6.
//    With PEAK_CLR on an idle cycle, the next sample max 2 (lane1) -> output 2/1.

Source files
------------

// File: rtl/nibble_sel_pkg.sv
// Shared encodings and the compare rule used by every node of the
// min/max selector tree and by the peak-hold stage.
package nibble_sel_pkg;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    // Returns 1 when b strictly beats a under the given mode. Equal values
    // never beat, so ties stay with a (the lower lane, or the held peak).
    // Operands are zero-extended to 32 bits by the caller, so lanes up to
    // 32 bits wide compare correctly as unsigned values.
    function automatic logic sel_better(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        mode);
        if (mode == MODE_MAX) begin
            return b > a;
        end
        return b < a;
    endfunction

endpackage

// File: rtl/nibble_select_node.sv
// One registered 2:1 compare node of the selector tree. Side a is always
// the lower-numbered half of the lanes, so keeping a on a tie gives the
// smallest winning index.
module nibble_select_node
    import nibble_sel_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_a_valid,
    input  logic             i_a_mode,
    input  logic [WIDTH-1:0] i_a_data,
    input  logic [IDX_W-1:0] i_a_idx,
    input  logic             i_b_valid,
    input  logic             i_b_mode,
    input  logic [WIDTH-1:0] i_b_data,
    input  logic [IDX_W-1:0] i_b_idx,
    output logic             o_valid,
    output logic             o_mode,
    output logic [WIDTH-1:0] o_data,
    output logic [IDX_W-1:0] o_idx
);

    logic w_valid;
    logic w_mode;
    logic w_pick_b;

    // Both children always carry the same sample, so their valid/mode
    // agree; merging them keeps every child output in use.
    always_comb begin
        w_valid  = i_a_valid | i_b_valid;
        w_mode   = i_a_valid ? i_a_mode : i_b_mode;
        w_pick_b = sel_better(32'(i_a_data), 32'(i_b_data), w_mode);
    end

    // Stage register: frozen while the pipe is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_mode  <= MODE_MAX;
            o_data  <= '0;
            o_idx   <= '0;
        end else if (i_en) begin
            o_valid <= w_valid;
            o_mode  <= w_mode;
            o_data  <= w_pick_b ? i_b_data : i_a_data;
            o_idx   <= w_pick_b ? i_b_idx  : i_a_idx;
        end
    end

endmodule

// File: rtl/nibble_select_tree.sv
// Pipelined min/max selector over N_IN lanes of WIDTH bits with an
// optional peak-hold on the output stage.
//
// Handshake: a sample moves in when IN_VALID & IN_READY, a result moves out
// when OUT_VALID & OUT_READY. IN_READY is low exactly when the output holds
// an unaccepted result; in that case every stage, including the output
// and peak registers, freezes (bubbles are not squeezed out).
module nibble_select_tree
    import nibble_sel_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N_IN  = 8
) (
    input  logic                    CLK,
    input  logic                    RESET_L,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [N_IN*WIDTH-1:0]   IN_DATA,
    input  logic                    MODE,
    input  logic                    PEAK_EN,
    input  logic                    PEAK_CLR,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [WIDTH-1:0]        OUT_DATA,
    output logic [$clog2(N_IN)-1:0] OUT_IDX
);

    localparam int LEVELS = $clog2(N_IN);

    logic              w_en;
    logic              w_load;
    logic              w_top_valid;
    logic              w_top_mode;
    logic [WIDTH-1:0]  w_top_data;
    logic [LEVELS-1:0] w_top_idx;
    logic              w_take_held;
    logic [WIDTH-1:0]  w_sel_data;
    logic [LEVELS-1:0] w_sel_idx;

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [LEVELS-1:0] r_out_idx;
    logic              r_peak_valid;
    logic [WIDTH-1:0]  r_peak_data;
    logic [LEVELS-1:0] r_peak_idx;

    // Tree: level l holds N_IN >> (l+1) nodes, each fed by node pair
    // (2k, 2k+1) of the level above, or by lane pair (2k, 2k+1) at level 0.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int NN = N_IN >> (l + 1);
        logic [NN-1:0]        w_valid;
        logic [NN-1:0]        w_mode;
        logic [NN*WIDTH-1:0]  w_data;
        logic [NN*LEVELS-1:0] w_idx;

        for (genvar k = 0; k < NN; k++) begin : g_node
            if (l == 0) begin : g_leaf
                nibble_select_node #(.WIDTH(WIDTH), .IDX_W(LEVELS)) u_node (
                    .i_clk     (CLK),
                    .i_rst_n   (RESET_L),
                    .i_en      (w_en),
                    .i_a_valid (IN_VALID),
                    .i_a_mode  (MODE),
                    .i_a_data  (IN_DATA[(2*k)*WIDTH +: WIDTH]),
                    .i_a_idx   (LEVELS'(2*k)),
                    .i_b_valid (IN_VALID),
                    .i_b_mode  (MODE),
                    .i_b_data  (IN_DATA[(2*k+1)*WIDTH +: WIDTH]),
                    .i_b_idx   (LEVELS'(2*k+1)),
                    .o_valid   (w_valid[k]),
                    .o_mode    (w_mode[k]),
                    .o_data    (w_data[k*WIDTH +: WIDTH]),
                    .o_idx     (w_idx[k*LEVELS +: LEVELS])
                );
            end else begin : g_inner
                nibble_select_node #(.WIDTH(WIDTH), .IDX_W(LEVELS)) u_node (
                    .i_clk     (CLK),
                    .i_rst_n   (RESET_L),
                    .i_en      (w_en),
                    .i_a_valid (g_lvl[l-1].w_valid[2*k]),
                    .i_a_mode  (g_lvl[l-1].w_mode[2*k]),
                    .i_a_data  (g_lvl[l-1].w_data[(2*k)*WIDTH +: WIDTH]),
                    .i_a_idx   (g_lvl[l-1].w_idx[(2*k)*LEVELS +: LEVELS]),
                    .i_b_valid (g_lvl[l-1].w_valid[2*k+1]),
                    .i_b_mode  (g_lvl[l-1].w_mode[2*k+1]),
                    .i_b_data  (g_lvl[l-1].w_data[(2*k+1)*WIDTH +: WIDTH]),
                    .i_b_idx   (g_lvl[l-1].w_idx[(2*k+1)*LEVELS +: LEVELS]),
                    .o_valid   (w_valid[k]),
                    .o_mode    (w_mode[k]),
                    .o_data    (w_data[k*WIDTH +: WIDTH]),
                    .o_idx     (w_idx[k*LEVELS +: LEVELS])
                );
            end
        end
    end

    // Flow control and the peak-hold choice for the sample leaving the tree.
    // A same-cycle PEAK_CLR hides the held value, so the new sample wins.
    always_comb begin
        w_en        = ~(r_out_valid & ~OUT_READY);
        w_top_valid = g_lvl[LEVELS-1].w_valid[0];
        w_top_mode  = g_lvl[LEVELS-1].w_mode[0];
        w_top_data  = g_lvl[LEVELS-1].w_data[WIDTH-1:0];
        w_top_idx   = g_lvl[LEVELS-1].w_idx[LEVELS-1:0];
        w_load      = w_en & w_top_valid;
        w_take_held = PEAK_EN & r_peak_valid & ~PEAK_CLR &
                      ~sel_better(32'(r_peak_data), 32'(w_top_data), w_top_mode);
        w_sel_data  = w_take_held ? r_peak_data : w_top_data;
        w_sel_idx   = w_take_held ? r_peak_idx  : w_top_idx;
    end

    // Output register: valid follows the last tree stage when not stalled;
    // data/index change only when a real sample loads.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
        end else if (w_en) begin
            r_out_valid <= w_top_valid;
            if (w_top_valid) begin
                r_out_data <= w_sel_data;
                r_out_idx  <= w_sel_idx;
            end
        end
    end

    // Peak register: clear first, then a peak-enabled load overwrites it.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_peak_valid <= 1'b0;
            r_peak_data  <= '0;
            r_peak_idx   <= '0;
        end else begin
            if (PEAK_CLR) begin
                r_peak_valid <= 1'b0;
            end
            if (w_load && PEAK_EN) begin
                r_peak_valid <= 1'b1;
                r_peak_data  <= w_sel_data;
                r_peak_idx   <= w_sel_idx;
            end
        end
    end

    assign IN_READY  = w_en;
    assign OUT_VALID = r_out_valid;
    assign OUT_DATA  = r_out_data;
    assign OUT_IDX   = r_out_idx;

endmodule

// File: tb/tb_nibble_select_tree.sv
// Directed bench for nibble_select_tree (WIDTH=4, N_IN=8).
module tb_nibble_select_tree;

  logic        CLK = 1'b0;
  logic        RESET_L;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_DATA;
  logic        MODE;
  logic        PEAK_EN;
  logic        PEAK_CLR;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [3:0]  OUT_DATA;
  logic [2:0]  OUT_IDX;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] stim_data [8];
  logic        stim_mode [8];

  // scoreboard: {idx, data}
  logic [6:0] exp_q [$];
  logic [6:0] obs_q [$];
  int         ocyc_q [$];
  int         acc_q [$];

  nibble_select_tree dut (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .MODE      (MODE),
    .PEAK_EN   (PEAK_EN),
    .PEAK_CLR  (PEAK_CLR),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_IDX   (OUT_IDX)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // monitor: records transfers half a cycle before the edge that commits them
  always @(negedge CLK) begin
    if (RESET_L) begin
      if (IN_VALID && IN_READY) acc_q.push_back(cyc);
      if (OUT_VALID && OUT_READY) begin
        obs_q.push_back({OUT_IDX, OUT_DATA});
        ocyc_q.push_back(cyc);
      end
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    ocyc_q.delete();
    acc_q.delete();
  endtask

  // driver: streams stim[0..n-1] with OUT_READY=1; PEAK_CLR high in cycle clr_at
  task automatic stream(input int n, input int cycles, input int clr_at);
    int i;
    i = 0;
    for (int t = 0; t < cycles; t++) begin
      @(posedge CLK); #1;
      OUT_READY = 1'b1;
      PEAK_CLR  = (t == clr_at);
      IN_VALID  = (i < n);
      if (i < n) begin
        IN_DATA = stim_data[i];
        MODE    = stim_mode[i];
      end
      @(negedge CLK);
      if (IN_VALID && IN_READY) i++;
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    PEAK_CLR = 1'b0;
  endtask

  task automatic test_reset();
    // power-on reset state
    RESET_L = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (OUT_VALID !== 1'b0 || OUT_DATA !== 4'h0 || OUT_IDX !== 3'd0) begin
      $display("FAIL reset_por: got v=%b d=%h i=%0d, need v=0 d=0 i=0", OUT_VALID, OUT_DATA, OUT_IDX);
      n_fail++;
    end
    @(negedge CLK); RESET_L = 1'b1; #1;
    n_checks++;
    if (IN_READY !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b need 1", IN_READY);
      n_fail++;
    end
    // one sample out so the output register is non-zero: F at lane 5
    clear_sb();
    stim_data[0] = 32'h00F00000; stim_mode[0] = 1'b0;
    stream(1, 8, -1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {3'd5, 4'hF}) begin
      $display("FAIL reset_preload: got n=%0d first=%h need n=1 %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 7'h0, {3'd5, 4'hF});
      n_fail++;
    end
    // three samples in flight, then reset
    clear_sb();
    stim_data[0] = 32'h11111111; stim_mode[0] = 1'b0;
    stim_data[1] = 32'h22222222; stim_mode[1] = 1'b0;
    stim_data[2] = 32'h33333333; stim_mode[2] = 1'b0;
    stream(3, 3, -1);
    RESET_L = 1'b0;
    #1;
    n_checks++;
    if (OUT_VALID !== 1'b0 || OUT_DATA !== 4'h0 || OUT_IDX !== 3'd0) begin
      $display("FAIL reset_mid: got v=%b d=%h i=%0d, need v=0 d=0 i=0", OUT_VALID, OUT_DATA, OUT_IDX);
      n_fail++;
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK); RESET_L = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    n_checks++;
    if (obs_q.size() != 0 || OUT_VALID !== 1'b0) begin
      $display("FAIL reset_flush: got %0d stale outputs v=%b, need 0 v=0", obs_q.size(), OUT_VALID);
      n_fail++;
    end
  endtask

  task automatic test_max();
    clear_sb();
    // lanes {0:3,1:9,2:F,3:1,4:F,5:0,6:2,7:8}
    stim_data[0] = 32'h820F1F93; stim_mode[0] = 1'b0;
    stream(1, 8, -1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {3'd2, 4'hF}) begin
      $display("FAIL max_result: got n=%0d first=%h need n=1 %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 7'h0, {3'd2, 4'hF});
      n_fail++;
    end
    n_checks++;
    if (obs_q.size() != 1 || acc_q.size() != 1 || ocyc_q[0] - acc_q[0] != 4) begin
      $display("FAIL max_latency: got %0d cycles need 4",
               (obs_q.size() > 0 && acc_q.size() > 0) ? ocyc_q[0] - acc_q[0] : -1);
      n_fail++;
    end
  endtask

  task automatic test_min_back_to_back();
    clear_sb();
    // all 7 except lanes 5 and 6 = 2
    stim_data[0] = 32'h72277777; stim_mode[0] = 1'b1;
    stream(1, 8, -1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {3'd5, 4'h2}) begin
      $display("FAIL min_result: got n=%0d first=%h need n=1 %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 7'h0, {3'd5, 4'h2});
      n_fail++;
    end
    clear_sb();
    stim_data[0] = 32'h12345678; stim_mode[0] = 1'b0;   // max 8 @0
    stim_data[1] = 32'h12345678; stim_mode[1] = 1'b1;   // min 1 @7
    stim_data[2] = 32'hA0A00000; stim_mode[2] = 1'b0;   // max A tie 5/7 -> 5
    exp_q.push_back({3'd0, 4'h8});
    exp_q.push_back({3'd7, 4'h1});
    exp_q.push_back({3'd5, 4'hA});
    stream(3, 10, -1);
    for (int e = 0; e < 3; e++) begin
      n_checks++;
      if (e >= obs_q.size()) begin
        $display("FAIL b2b_out[%0d]: got nothing need %h", e, exp_q[e]);
        n_fail++;
      end else if (obs_q[e] !== exp_q[e]) begin
        $display("FAIL b2b_out[%0d]: got %h need %h", e, obs_q[e], exp_q[e]);
        n_fail++;
      end
    end
    n_checks++;
    if (ocyc_q.size() != 3 || ocyc_q[1] != ocyc_q[0] + 1 || ocyc_q[2] != ocyc_q[1] + 1) begin
      $display("FAIL b2b_rate: got %0d outputs, need 3 on consecutive cycles", ocyc_q.size());
      n_fail++;
    end
  endtask

  task automatic test_stall();
    int i;
    int stalled;
    clear_sb();
    stim_data[0] = 32'h00000001; stim_data[1] = 32'h00000020;
    stim_data[2] = 32'h00000300; stim_data[3] = 32'h00004000;
    stim_data[4] = 32'h00050000; stim_data[5] = 32'h00600000;
    for (int s = 0; s < 6; s++) begin
      stim_mode[s] = 1'b0;
      exp_q.push_back({3'(s), 4'(s + 1)});
    end
    i = 0;
    stalled = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge CLK); #1;
      OUT_READY = !(t >= 5 && t < 10);
      IN_VALID  = (i < 6);
      if (i < 6) begin
        IN_DATA = stim_data[i];
        MODE    = stim_mode[i];
      end
      @(negedge CLK);
      if (OUT_VALID && !OUT_READY) begin
        stalled++;
        n_checks++;
        if (IN_READY !== 1'b0) begin
          $display("FAIL stall_in_ready t=%0d: got %b need 0", t, IN_READY);
          n_fail++;
        end
        n_checks++;
        if (OUT_DATA !== 4'h2 || OUT_IDX !== 3'd1) begin
          $display("FAIL stall_hold t=%0d: got %h/%0d need 2/1", t, OUT_DATA, OUT_IDX);
          n_fail++;
        end
      end
      if (IN_VALID && IN_READY) i++;
    end
    @(posedge CLK); #1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    n_checks++;
    if (stalled != 5) begin
      $display("FAIL stall_cycles: got %0d need 5", stalled);
      n_fail++;
    end
    for (int e = 0; e < 6; e++) begin
      n_checks++;
      if (e >= obs_q.size()) begin
        $display("FAIL stall_out[%0d]: got nothing need %h", e, exp_q[e]);
        n_fail++;
      end else if (obs_q[e] !== exp_q[e]) begin
        $display("FAIL stall_out[%0d]: got %h need %h", e, obs_q[e], exp_q[e]);
        n_fail++;
      end
    end
    n_checks++;
    if (obs_q.size() != 6) begin
      $display("FAIL stall_count: got %0d outputs need 6", obs_q.size());
      n_fail++;
    end
  endtask

  task automatic load_peak_stim();
    stim_data[0] = 32'h11115111; stim_mode[0] = 1'b0;   // 5 @3
    stim_data[1] = 32'h22222229; stim_mode[1] = 1'b0;   // 9 @0
    stim_data[2] = 32'h43333333; stim_mode[2] = 1'b0;   // 4 @7
    stim_data[3] = 32'h09000000; stim_mode[3] = 1'b0;   // 9 @6
  endtask

  task automatic test_peak();
    clear_sb();
    PEAK_EN = 1'b1;
    load_peak_stim();
    exp_q.push_back({3'd3, 4'h5});
    exp_q.push_back({3'd0, 4'h9});
    exp_q.push_back({3'd0, 4'h9});
    exp_q.push_back({3'd0, 4'h9});
    stream(4, 10, -1);
    for (int e = 0; e < 4; e++) begin
      n_checks++;
      if (e >= obs_q.size()) begin
        $display("FAIL peak_out[%0d]: got nothing need %h", e, exp_q[e]);
        n_fail++;
      end else if (obs_q[e] !== exp_q[e]) begin
        $display("FAIL peak_out[%0d]: got %h need %h", e, obs_q[e], exp_q[e]);
        n_fail++;
      end
    end
  endtask

  task automatic test_peak_clr();
    // idle clear, then rerun with clear on the 4th load (cycle 6)
    @(posedge CLK); #1; PEAK_CLR = 1'b1;
    @(posedge CLK); #1; PEAK_CLR = 1'b0;
    clear_sb();
    load_peak_stim();
    exp_q.push_back({3'd3, 4'h5});
    exp_q.push_back({3'd0, 4'h9});
    exp_q.push_back({3'd0, 4'h9});
    exp_q.push_back({3'd6, 4'h9});
    stream(4, 10, 6);
    for (int e = 0; e < 4; e++) begin
      n_checks++;
      if (e >= obs_q.size()) begin
        $display("FAIL peakclr_out[%0d]: got nothing need %h", e, exp_q[e]);
        n_fail++;
      end else if (obs_q[e] !== exp_q[e]) begin
        $display("FAIL peakclr_out[%0d]: got %h need %h", e, obs_q[e], exp_q[e]);
        n_fail++;
      end
    end
    // idle-cycle clear, then a small sample becomes the new peak
    @(posedge CLK); #1; PEAK_CLR = 1'b1;
    @(posedge CLK); #1; PEAK_CLR = 1'b0;
    clear_sb();
    stim_data[0] = 32'h00000020; stim_mode[0] = 1'b0;   // 2 @1
    stream(1, 8, -1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {3'd1, 4'h2}) begin
      $display("FAIL peakclr_idle: got n=%0d first=%h need n=1 %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 7'h0, {3'd1, 4'h2});
      n_fail++;
    end
    PEAK_EN = 1'b0;
  endtask

  initial begin
    RESET_L   = 1'b0;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    MODE      = 1'b0;
    PEAK_EN   = 1'b0;
    PEAK_CLR  = 1'b0;
    OUT_READY = 1'b1;
    test_reset();
    test_max();
    test_min_back_to_back();
    test_stall();
    test_peak();
    test_peak_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
